// File: rtl/nasti_pkg.sv
`default_nettype none
// ============================================================================
// nasti_pkg
// Shared constants, payload-width helpers and the skid buffer state type
// for the NASTI register slice.
// Revision: 1.0 - initial release
// ============================================================================
package nasti_pkg;

  // Fixed AXI4 field widths
  localparam int c_len_w    = 8;
  localparam int c_size_w   = 3;
  localparam int c_burst_w  = 2;
  localparam int c_lock_w   = 1;
  localparam int c_cache_w  = 4;
  localparam int c_prot_w   = 3;
  localparam int c_qos_w    = 4;
  localparam int c_region_w = 4;
  localparam int c_resp_w   = 2;
  localparam int c_last_w   = 1;

  // Two-entry skid buffer occupancy
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // AW / AR flat payload width
  function automatic int ax_width(input int id_w, input int addr_w, input int user_w);
    return id_w + addr_w + c_len_w + c_size_w + c_burst_w + c_lock_w +
           c_cache_w + c_prot_w + c_qos_w + c_region_w + user_w;
  endfunction

  // W flat payload width (data + strobe + last + user)
  function automatic int w_width(input int data_w, input int user_w);
    return data_w + data_w / 8 + c_last_w + user_w;
  endfunction

  // B flat payload width
  function automatic int b_width(input int id_w, input int user_w);
    return id_w + c_resp_w + user_w;
  endfunction

  // R flat payload width
  function automatic int r_width(input int id_w, input int data_w, input int user_w);
    return id_w + data_w + c_resp_w + c_last_w + user_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nasti_channel.sv
`default_nettype none
// ============================================================================
// nasti_channel
// NASTI (AXI4) five-channel bundle. The master modport drives AW/W/AR and
// the B/R ready lines; the slave modport is the mirror image.
// Revision: 1.0 - initial release
// ============================================================================
interface nasti_channel #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int USER_WIDTH = 1
);
  // AW
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;
  // W
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;
  // B
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;
  // AR
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;
  // R
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface
`default_nettype wire

// File: rtl/nasti_skid_buf.sv
`default_nettype none
// ============================================================================
// nasti_skid_buf
// Two-entry registered skid buffer for one valid/ready channel. Both the
// output payload/valid and the input ready come straight from flops, so no
// combinational path crosses the buffer in either direction.
// Revision: 1.0 - initial release
// ============================================================================
module nasti_skid_buf
  import nasti_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  // upstream side
  input  wire logic             i_valid,
  output logic                  o_ready,
  input  wire logic [WIDTH-1:0] i_data,
  // downstream side
  output logic                  o_valid,
  input  wire logic             i_ready,
  output logic [WIDTH-1:0]      o_data
);

  skid_state_e      r_state;
  skid_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_valid & o_ready;
  assign w_pop  = o_valid & i_ready;
  assign o_data = r_main;

  // State register: only the occupancy is reset, buffered beats are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: track occupancy from push/pop of this cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: begin
        if (w_push) w_state_nxt = ONE;
      end
      ONE: begin
        if (w_push && !w_pop)      w_state_nxt = FULL;
        else if (w_pop && !w_push) w_state_nxt = EMPTY;
      end
      FULL: begin
        if (w_pop) w_state_nxt = ONE;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Outputs: ready is held low while in reset so nothing is accepted then.
  always_comb begin
    o_valid = (r_state != EMPTY);
    o_ready = (r_state != FULL) && !rst;
  end

  // Payload: main holds the head beat, skid catches the beat arriving while
  // the head is stalled. No reset needed; validity lives in the state.
  always_ff @(posedge clk) begin
    case (r_state)
      EMPTY: begin
        if (w_push) r_main <= i_data;
      end
      ONE: begin
        if (w_push && w_pop) r_main <= i_data;
        else if (w_push)     r_skid <= i_data;
      end
      FULL: begin
        if (w_pop) r_main <= r_skid;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/nasti_reg_slice.sv
`default_nettype none
// ============================================================================
// nasti_reg_slice
// Fully registered NASTI (AXI4) pipeline stage. AW, W and AR flow s -> m,
// B and R flow m -> s, each through its own two-entry skid buffer. Payload
// fields are packed into flat vectors around the buffers.
// Revision: 1.0 - initial release
// ============================================================================
module nasti_reg_slice
  import nasti_pkg::*;
#(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int USER_WIDTH = 1
) (
  input  wire logic     clk,
  input  wire logic     rst,
  nasti_channel.slave   s,
  nasti_channel.master  m
);

  localparam int c_ax_w = ax_width(ID_WIDTH, ADDR_WIDTH, USER_WIDTH);
  localparam int c_w_w  = w_width(DATA_WIDTH, USER_WIDTH);
  localparam int c_b_w  = b_width(ID_WIDTH, USER_WIDTH);
  localparam int c_r_w  = r_width(ID_WIDTH, DATA_WIDTH, USER_WIDTH);

  logic [c_ax_w-1:0] w_aw_in, w_aw_out;
  logic [c_w_w-1:0]  w_w_in,  w_w_out;
  logic [c_ax_w-1:0] w_ar_in, w_ar_out;
  logic [c_b_w-1:0]  w_b_in,  w_b_out;
  logic [c_r_w-1:0]  w_r_in,  w_r_out;

  // AW: s -> m
  assign w_aw_in = {s.aw_id, s.aw_addr, s.aw_len, s.aw_size, s.aw_burst, s.aw_lock,
                    s.aw_cache, s.aw_prot, s.aw_qos, s.aw_region, s.aw_user};
  assign {m.aw_id, m.aw_addr, m.aw_len, m.aw_size, m.aw_burst, m.aw_lock,
          m.aw_cache, m.aw_prot, m.aw_qos, m.aw_region, m.aw_user} = w_aw_out;

  nasti_skid_buf #(.WIDTH(c_ax_w)) u_aw (
    .clk     (clk),
    .rst     (rst),
    .i_valid (s.aw_valid),
    .o_ready (s.aw_ready),
    .i_data  (w_aw_in),
    .o_valid (m.aw_valid),
    .i_ready (m.aw_ready),
    .o_data  (w_aw_out)
  );

  // W: s -> m
  assign w_w_in = {s.w_data, s.w_strb, s.w_last, s.w_user};
  assign {m.w_data, m.w_strb, m.w_last, m.w_user} = w_w_out;

  nasti_skid_buf #(.WIDTH(c_w_w)) u_w (
    .clk     (clk),
    .rst     (rst),
    .i_valid (s.w_valid),
    .o_ready (s.w_ready),
    .i_data  (w_w_in),
    .o_valid (m.w_valid),
    .i_ready (m.w_ready),
    .o_data  (w_w_out)
  );

  // AR: s -> m
  assign w_ar_in = {s.ar_id, s.ar_addr, s.ar_len, s.ar_size, s.ar_burst, s.ar_lock,
                    s.ar_cache, s.ar_prot, s.ar_qos, s.ar_region, s.ar_user};
  assign {m.ar_id, m.ar_addr, m.ar_len, m.ar_size, m.ar_burst, m.ar_lock,
          m.ar_cache, m.ar_prot, m.ar_qos, m.ar_region, m.ar_user} = w_ar_out;

  nasti_skid_buf #(.WIDTH(c_ax_w)) u_ar (
    .clk     (clk),
    .rst     (rst),
    .i_valid (s.ar_valid),
    .o_ready (s.ar_ready),
    .i_data  (w_ar_in),
    .o_valid (m.ar_valid),
    .i_ready (m.ar_ready),
    .o_data  (w_ar_out)
  );

  // B: m -> s
  assign w_b_in = {m.b_id, m.b_resp, m.b_user};
  assign {s.b_id, s.b_resp, s.b_user} = w_b_out;

  nasti_skid_buf #(.WIDTH(c_b_w)) u_b (
    .clk     (clk),
    .rst     (rst),
    .i_valid (m.b_valid),
    .o_ready (m.b_ready),
    .i_data  (w_b_in),
    .o_valid (s.b_valid),
    .i_ready (s.b_ready),
    .o_data  (w_b_out)
  );

  // R: m -> s
  assign w_r_in = {m.r_id, m.r_data, m.r_resp, m.r_last, m.r_user};
  assign {s.r_id, s.r_data, s.r_resp, s.r_last, s.r_user} = w_r_out;

  nasti_skid_buf #(.WIDTH(c_r_w)) u_r (
    .clk     (clk),
    .rst     (rst),
    .i_valid (m.r_valid),
    .o_ready (m.r_ready),
    .i_data  (w_r_in),
    .o_valid (s.r_valid),
    .i_ready (s.r_ready),
    .o_data  (w_r_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_nasti_reg_slice.sv
`default_nettype none
// ============================================================================
// tb_nasti_reg_slice
// Self-checking bench: each channel is modelled as an ideal two-deep FIFO
// with one cycle of latency; DUT outputs are compared against it every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_nasti_reg_slice;
  import nasti_pkg::*;

  localparam int c_ax_w = ax_width(8, 16, 1);
  localparam int c_w_w  = w_width(128, 1);
  localparam int c_b_w  = b_width(8, 1);
  localparam int c_r_w  = r_width(8, 128, 1);
  // channel order: 0 AW, 1 W, 2 AR, 3 B, 4 R
  localparam int c_width [5] = '{c_ax_w, c_w_w, c_ax_w, c_b_w, c_r_w};

  typedef logic [255:0] beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nasti_channel s_if ();
  nasti_channel m_if ();

  nasti_reg_slice dut (
    .clk (clk),
    .rst (rst),
    .s   (s_if),
    .m   (m_if)
  );

  // stimulus for the current cycle
  logic  in_valid  [5];
  beat_t in_data   [5];
  logic  out_ready [5];
  // sampled DUT outputs
  logic  dut_ov [5];
  beat_t dut_od [5];
  logic  dut_ir [5];
  // reference: beats accepted but not yet taken downstream
  beat_t model_q [5][$];

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  function automatic beat_t rnd_beat();
    beat_t r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic beat_t width_mask(input int w);
    beat_t ones;
    ones = '1;
    return ones >> (256 - w);
  endfunction

  task automatic check(input string name, input int ch, input beat_t act, input beat_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s ch%0d actual=%0h expected=%0h", name, ch, act, exp);
    end
  endtask

  task automatic drive();
    {s_if.aw_id, s_if.aw_addr, s_if.aw_len, s_if.aw_size, s_if.aw_burst, s_if.aw_lock,
     s_if.aw_cache, s_if.aw_prot, s_if.aw_qos, s_if.aw_region, s_if.aw_user} = in_data[0][c_ax_w-1:0];
    s_if.aw_valid = in_valid[0];
    m_if.aw_ready = out_ready[0];
    {s_if.w_data, s_if.w_strb, s_if.w_last, s_if.w_user} = in_data[1][c_w_w-1:0];
    s_if.w_valid = in_valid[1];
    m_if.w_ready = out_ready[1];
    {s_if.ar_id, s_if.ar_addr, s_if.ar_len, s_if.ar_size, s_if.ar_burst, s_if.ar_lock,
     s_if.ar_cache, s_if.ar_prot, s_if.ar_qos, s_if.ar_region, s_if.ar_user} = in_data[2][c_ax_w-1:0];
    s_if.ar_valid = in_valid[2];
    m_if.ar_ready = out_ready[2];
    {m_if.b_id, m_if.b_resp, m_if.b_user} = in_data[3][c_b_w-1:0];
    m_if.b_valid = in_valid[3];
    s_if.b_ready = out_ready[3];
    {m_if.r_id, m_if.r_data, m_if.r_resp, m_if.r_last, m_if.r_user} = in_data[4][c_r_w-1:0];
    m_if.r_valid = in_valid[4];
    s_if.r_ready = out_ready[4];
  endtask

  task automatic sample();
    for (int c = 0; c < 5; c++) dut_od[c] = '0;
    dut_od[0][c_ax_w-1:0] = {m_if.aw_id, m_if.aw_addr, m_if.aw_len, m_if.aw_size, m_if.aw_burst,
                             m_if.aw_lock, m_if.aw_cache, m_if.aw_prot, m_if.aw_qos,
                             m_if.aw_region, m_if.aw_user};
    dut_od[1][c_w_w-1:0]  = {m_if.w_data, m_if.w_strb, m_if.w_last, m_if.w_user};
    dut_od[2][c_ax_w-1:0] = {m_if.ar_id, m_if.ar_addr, m_if.ar_len, m_if.ar_size, m_if.ar_burst,
                             m_if.ar_lock, m_if.ar_cache, m_if.ar_prot, m_if.ar_qos,
                             m_if.ar_region, m_if.ar_user};
    dut_od[3][c_b_w-1:0]  = {s_if.b_id, s_if.b_resp, s_if.b_user};
    dut_od[4][c_r_w-1:0]  = {s_if.r_id, s_if.r_data, s_if.r_resp, s_if.r_last, s_if.r_user};
    dut_ov[0] = m_if.aw_valid; dut_ir[0] = s_if.aw_ready;
    dut_ov[1] = m_if.w_valid;  dut_ir[1] = s_if.w_ready;
    dut_ov[2] = m_if.ar_valid; dut_ir[2] = s_if.ar_ready;
    dut_ov[3] = s_if.b_valid;  dut_ir[3] = m_if.b_ready;
    dut_ov[4] = s_if.r_valid;  dut_ir[4] = m_if.r_ready;
  endtask

  // One clock: apply stimulus, advance the FIFO model at the edge, then
  // compare every channel's valid, ready and head payload.
  task automatic step();
    bit had_beat;
    bit had_room;
    drive();
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      if (rst) begin
        model_q[c].delete();
      end else begin
        had_beat = (model_q[c].size() != 0);
        had_room = (model_q[c].size() < 2);
        if (had_beat && out_ready[c]) void'(model_q[c].pop_front());
        if (in_valid[c] && had_room) model_q[c].push_back(in_data[c] & width_mask(c_width[c]));
      end
    end
    #1;
    sample();
    for (int c = 0; c < 5; c++) begin
      check("out_valid", c, beat_t'(dut_ov[c]), beat_t'(model_q[c].size() != 0));
      check("in_ready",  c, beat_t'(dut_ir[c]), beat_t'(!rst && (model_q[c].size() < 2)));
      if (model_q[c].size() != 0) check("payload", c, dut_od[c], model_q[c][0]);
    end
  endtask

  task automatic idle_all();
    for (int c = 0; c < 5; c++) begin
      in_valid[c]  = 1'b0;
      in_data[c]   = '0;
      out_ready[c] = 1'b1;
    end
  endtask

  initial begin
    int accepted;
    int seq;
    int pv;
    int pr;

    idle_all();

    // reset state
    rst = 1'b1;
    step();
    check("rst_s_aw_ready", 0, beat_t'(s_if.aw_ready), '0);
    check("rst_m_aw_valid", 0, beat_t'(m_if.aw_valid), '0);
    check("rst_m_b_ready",  3, beat_t'(m_if.b_ready),  '0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_s_w_ready", 1, beat_t'(s_if.w_ready), beat_t'(1));

    // single write: AW + one W beat, then B id 3
    in_data[0][c_ax_w-1:0] = {8'd3, 16'h0040, 8'd0, 3'd4, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0};
    in_data[1][c_w_w-1:0]  = {{15{8'h5A}}, 8'hA5, 16'hFFFF, 1'b1, 1'b0};
    in_valid[0] = 1'b1;
    in_valid[1] = 1'b1;
    step();
    check("wr_aw_valid", 0, beat_t'(m_if.aw_valid), beat_t'(1));
    check("wr_aw_addr",  0, beat_t'(m_if.aw_addr),  beat_t'(16'h0040));
    check("wr_w_data",   1, beat_t'(m_if.w_data[7:0]), beat_t'(8'hA5));
    check("wr_w_strb",   1, beat_t'(m_if.w_strb),   beat_t'(16'hFFFF));
    idle_all();
    step();
    check("wr_aw_drained", 0, beat_t'(m_if.aw_valid), '0);
    in_data[3][c_b_w-1:0] = {8'd3, 2'b00, 1'b0};
    in_valid[3] = 1'b1;
    step();
    check("b_valid", 3, beat_t'(s_if.b_valid), beat_t'(1));
    check("b_id",    3, beat_t'(s_if.b_id),    beat_t'(3));
    idle_all();
    step();

    // read burst of 8 beats, both readies high
    for (int b = 0; b < 8; b++) begin
      in_data[4] = '0;
      in_data[4][c_r_w-1:0] = {8'd5, 128'(32'hC0DE0000 + b), 2'b00, (b == 7), 1'b0};
      in_valid[4] = 1'b1;
      step();
      check("rd_r_valid", 4, beat_t'(s_if.r_valid), beat_t'(1));
      check("rd_r_last",  4, beat_t'(s_if.r_last),  beat_t'(b == 7));
      check("rd_r_data",  4, beat_t'(s_if.r_data[7:0]), beat_t'(b));
    end
    idle_all();
    step();
    check("rd_done", 4, beat_t'(s_if.r_valid), '0);

    // backpressure on AW for 4 cycles
    out_ready[0] = 1'b0;
    accepted = 0;
    seq = 0;
    for (int k = 0; k < 4; k++) begin
      check("bp_ready", 0, beat_t'(s_if.aw_ready), beat_t'(k < 2));
      in_data[0] = '0;
      in_data[0][c_ax_w-1:0] = {8'd1, 16'(seq), 8'd0, 3'd4, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0};
      in_valid[0] = 1'b1;
      if (s_if.aw_ready) begin
        accepted++;
        seq++;
      end
      step();
    end
    check("bp_accepted", 0, beat_t'(accepted), beat_t'(2));
    check("bp_head", 0, beat_t'(m_if.aw_addr), beat_t'(0));
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    step();
    check("bp_second", 0, beat_t'(m_if.aw_addr), beat_t'(1));
    step();
    check("bp_drained", 0, beat_t'(m_if.aw_valid), '0);

    // reset during an 8-beat write burst with W stalled downstream
    idle_all();
    out_ready[1] = 1'b0;
    in_data[0][c_ax_w-1:0] = {8'd2, 16'h0200, 8'd7, 3'd4, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0};
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data[1] = '0;
      in_data[1][c_w_w-1:0] = {128'(k + 16'h1000), 16'hFFFF, 1'b0, 1'b0};
      in_valid[1] = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    check("mid_rst_m_w_valid",  1, beat_t'(m_if.w_valid),  '0);
    check("mid_rst_s_w_ready",  1, beat_t'(s_if.w_ready),  '0);
    check("mid_rst_s_r_valid",  4, beat_t'(s_if.r_valid),  '0);
    check("mid_rst_m_r_ready",  4, beat_t'(m_if.r_ready),  '0);
    rst = 1'b0;
    idle_all();
    step();
    check("post_rst_w_empty", 1, beat_t'(m_if.w_valid), '0);
    in_data[0][c_ax_w-1:0] = {8'd4, 16'h0100, 8'd0, 3'd4, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0};
    in_data[1][c_w_w-1:0]  = {128'h0000_1111_2222_3333_4444_5555_6666_7777, 16'hFFFF, 1'b1, 1'b0};
    in_valid[0] = 1'b1;
    in_valid[1] = 1'b1;
    step();
    check("fresh_aw_addr", 0, beat_t'(m_if.aw_addr), beat_t'(16'h0100));
    check("fresh_w_last",  1, beat_t'(m_if.w_last),  beat_t'(1));
    idle_all();
    step();

    // randomized valid/ready on all channels
    for (int n = 0; n < 10000; n++) begin
      pv = 50 + ((n / 400) % 6) * 10;
      pr = 50 + (((n / 400) + 3) % 6) * 10;
      for (int c = 0; c < 5; c++) begin
        in_valid[c]  = ($urandom_range(0, 99) < pv);
        out_ready[c] = ($urandom_range(0, 99) < pr);
        in_data[c]   = rnd_beat();
      end
      rst = (n == 5000 || n == 5001);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nasti_reg_slice.md
# nasti_reg_slice

Fully registered NASTI (AXI4) pipeline stage inserted directly upstream of the BRAM controller wrapper, between the memory crossbar master port and the controller's slave port. It breaks every combinational valid/ready and payload path on all five channels (AW, W, B, AR, R). This lets the on-chip BRAM sit far from the crossbar without limiting Fmax, while sustaining one beat per cycle per channel.

## Interface
- ID_WIDTH, 8, AW/AR/B/R id width
- ADDR_WIDTH, 16, AW/AR address width (matches controller)
- DATA_WIDTH, 128, W/R data width; strobe is DATA_WIDTH/8
- USER_WIDTH, 1, user field width, passed through
- clk  input  1  single clock for both sides
- rst  input  1  asynchronous, active-high reset
- s  nasti_channel.slave  param  upstream side, faces crossbar
- m  nasti_channel.master  param  downstream side, faces BRAM controller

## Operation
- AW, W and AR run forward s→m. B and R run reverse m→s. Each channel gets one independent 2-entry skid buffer.
- Payload is every non-handshake field of the channel. It passes bit-exact, in order, with no reordering across or within channels.
- Buffer state machine, per channel:
  - EMPTY:
    - push → ONE
  - ONE:
    - push & !pop → FULL
    - pop & !push → EMPTY
    - push & pop → ONE, with the main register reloaded from input
  - FULL:
    - pop → ONE, with the main register taking the skid register
    - no push possible in FULL
- push = in_valid & in_ready. pop = out_valid & out_ready.
- out_valid = (state != EMPTY). out_data = main register.
- in_ready = (state != FULL) & !rst. It depends only on the state register and rst; there is no path from out_ready.
- Skid register is written only on push while in ONE and !pop.
- Payload registers are not reset; only the state registers are.
- No protocol checking, ID manipulation, or burst splitting; w_last/r_last are ordinary payload.

## Timing
- Forward latency: a beat accepted at edge N is visible at out at edge N (cycle N+1), so exactly 1 cycle.
- Throughput: 1 beat/cycle per channel when out_ready is held high.
- Backpressure: after out_ready deasserts, up to 2 beats are absorbed, then in_ready drops on the next cycle.
- Reset values, held throughout reset:
  - all m.*_valid and s.b_valid/s.r_valid = 0
  - all s.*_ready and m.b_ready/m.r_ready = 0
  - state = EMPTY
- in_ready returns to 1 in the first cycle after rst falls.
- Reset mid-burst: all buffered beats are discarded. Upstream and downstream must be reset in the same cycle; that is a system requirement, not checked here.
- Simultaneous push and pop in ONE: the state is unchanged and no bubble is inserted.
- Simultaneous pop in FULL with an in_valid that is not accepted: the beat is held upstream (ready was 0) and accepted the following cycle.

## Structure
- Shared package nasti_pkg holds:
  - per-channel payload width constants derived from ID/ADDR/DATA/USER widths (AW/AR: id+addr+len8+size3+burst2+lock+cache4+prot3+qos4+region4+user; W: data+strb+last+user; B: id+resp2+user; R: id+data+resp2+last+user)
  - the skid state enum {EMPTY, ONE, FULL}
- One sub-module, nasti_skid_buf #(WIDTH), instantiated five times. The top packs and unpacks the interface fields into flat vectors around it.

## Test plan
- Single write: AW addr 0x0040 len 0 plus one W beat (strb 0xFFFF, data 0x…A5) → m.aw_valid and m.w_valid rise 1 cycle after s handshake with identical fields. B id 3 returns on s 1 cycle after m.b handshake.
- Read burst: AR len 7 with m.r_ready and s.r_ready tied 1 → 8 R beats on s on consecutive cycles, each 1 cycle behind m. r_last is set only on beat 8.
- Backpressure: m.aw_ready = 0 for 4 cycles while s drives AW every cycle → exactly 2 accepted. s.aw_ready is 0 from the third cycle. After release, beats emerge in original order with no loss or duplication.
- Randomised valid/ready on all five channels for 10k cycles against a per-channel FIFO scoreboard → zero mismatches. Throughput is 1 beat/cycle whenever both sides are ready.
- Reset during an 8-beat write burst after beat 3 → all valids/readies read 0 during reset. After release, state is EMPTY and a fresh AW/W transaction passes cleanly.
